// File: rtl/cpu_seq_pkg.sv
// Shared types and default widths for the lab CPU fetch sequencer.
// PERF_CNT_EN (optional) adds the retired/cycle performance counters.
package cpu_seq_pkg;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake and bus signals between the sequencer and the rest of the CPU.
// master = sequencer side, slave = memories / control unit / datapath side.
interface fetch_seq_if #(parameter int PC_W = cpu_seq_pkg::PC_W) ();

  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            branch;
  logic            jmp_ctrl;
  logic            done_ctrl;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            branch_cond;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic            mem_ack;

  logic [PC_W-1:0] pc;
  logic            ir_load;
  logic            mem_req;
  logic            mem_we;
  logic            rf_we;
  logic            busy;
  logic            halted;

  modport master (
    input  start, start_pc, branch, jmp_ctrl, done_ctrl, mem_read, mem_write,
           reg_write, branch_cond, branch_target, jump_target, mem_ack,
    output pc, ir_load, mem_req, mem_we, rf_we, busy, halted
  );

  modport slave (
    output start, start_pc, branch, jmp_ctrl, done_ctrl, mem_read, mem_write,
           reg_write, branch_cond, branch_target, jump_target, mem_ack,
    input  pc, ir_load, mem_req, mem_we, rf_we, busy, halted
  );

endinterface

// File: rtl/perf_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module perf_counter #(
  parameter int W = cpu_seq_pkg::CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and gates phase strobes.
// Define PERF_CNT_EN to add retired_cnt / cycle_cnt outputs.
module fetch_sequencer
  import cpu_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  fetch_seq_if.master       bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
`endif
);

  seq_state_t      state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_nx = S_FETCH;
          pc_nx    = bus.start_pc;
        end
      end
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (bus.done_ctrl)
          state_nx = S_HALT;
        else if (bus.mem_read || bus.mem_write)
          state_nx = S_MEM;
        else
          state_nx = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ack)
          state_nx = S_WB;
      end
      S_WB: begin
        state_nx = S_FETCH;
        // jump outranks a taken branch when both are decoded
        if (bus.jmp_ctrl)
          pc_nx = bus.jump_target;
        else if (bus.branch && bus.branch_cond)
          pc_nx = bus.branch_target;
        else
          pc_nx = pc_q + PC_W'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.ir_load = (state == S_FETCH);
  assign bus.mem_req = (state == S_MEM);
  assign bus.mem_we  = (state == S_MEM) && bus.mem_write;
  assign bus.rf_we   = (state == S_WB) && bus.reg_write;
  assign bus.busy    = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted  = (state == S_HALT);

`ifdef PERF_CNT_EN
  logic perf_clear;
  logic retire_evt;

  assign perf_clear = bus.start && ((state == S_IDLE) || (state == S_HALT));
  assign retire_evt = (state == S_WB) || ((state == S_EXEC) && bus.done_ctrl);

  perf_counter #(.W(CNT_W)) u_retired (
    .clock  (clock),
    .reset  (reset),
    .enable (retire_evt),
    .clear  (perf_clear),
    .count  (retired_cnt)
  );

  perf_counter #(.W(CNT_W)) u_cycles (
    .clock  (clock),
    .reset  (reset),
    .enable (bus.busy),
    .clear  (perf_clear),
    .count  (cycle_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized instruction-level checks of fetch_sequencer.
module tb_fetch_sequencer;
  import cpu_seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_seq_if bus ();

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt, cycle_cnt;
`endif

  fetch_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // instruction-level reference model
  logic [PC_W-1:0] m_pc;
  int              m_ret;
  int              m_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    bus.start    = 1'($urandom);
    bus.start_pc = 8'($urandom);
    bus.mem_ack  = 1'($urandom);
  endtask

  task automatic do_start(input logic [PC_W-1:0] spc);
    bus.start    = 1'b1;
    bus.start_pc = spc;
    tick();
    bus.start = 1'b0;
    m_pc  = spc;
    m_ret = 0;
    m_cyc = 0;
    check("start_fetch_pc", bus.pc, m_pc);
    check("start_ir_load", bus.ir_load, 1'b1);
  endtask

  // Executes one instruction starting from a FETCH sample point; returns in
  // the next FETCH (or in HALT for a done instruction).
  task automatic do_instr(input logic br, input logic bc, input logic jmp,
                          input logic done, input logic mr, input logic mw,
                          input logic rw, input logic [PC_W-1:0] bt,
                          input logic [PC_W-1:0] jt, input int waits);
    bus.branch = br; bus.branch_cond = bc; bus.jmp_ctrl = jmp;
    bus.done_ctrl = done; bus.mem_read = mr; bus.mem_write = mw;
    bus.reg_write = rw; bus.branch_target = bt; bus.jump_target = jt;
    check("fetch_pc", bus.pc, m_pc);
    check("fetch_busy", bus.busy, 1'b1);
    noise();
    tick(); m_cyc++;
    check("decode_strobes", {bus.ir_load, bus.mem_req, bus.rf_we}, 3'b000);
    noise();
    tick(); m_cyc++;
    check("exec_strobes", {bus.ir_load, bus.mem_req, bus.rf_we, bus.busy}, 4'b0001);
    noise();
    if (done) begin
      tick(); m_cyc++; m_ret++;
      bus.start = 1'b0;
      check("halt_halted", bus.halted, 1'b1);
      check("halt_busy", bus.busy, 1'b0);
      check("halt_pc", bus.pc, m_pc);
      check("halt_rf_we", bus.rf_we, 1'b0);
      return;
    end
    if (mr || mw) begin
      for (int w = 0; w <= waits; w++) begin
        tick(); m_cyc++;
        check("mem_req", bus.mem_req, 1'b1);
        check("mem_we", bus.mem_we, mw);
        check("mem_rf_we", bus.rf_we, 1'b0);
        noise();
        bus.mem_ack = (w == waits);
      end
    end
    tick(); m_cyc++;
    check("wb_rf_we", bus.rf_we, rw);
    check("wb_mem_req", bus.mem_req, 1'b0);
    check("wb_pc_old", bus.pc, m_pc);
    noise();
    if (jmp)            m_pc = jt;
    else if (br && bc)  m_pc = bt;
    else                m_pc = m_pc + 1;
    m_ret++;
    tick(); m_cyc++;
    check("next_fetch_ir_load", bus.ir_load, 1'b1);
    check("next_fetch_pc", bus.pc, m_pc);
  endtask

  initial begin
    bus.start = 0; bus.start_pc = 0; bus.branch = 0; bus.jmp_ctrl = 0;
    bus.done_ctrl = 0; bus.mem_read = 0; bus.mem_write = 0; bus.reg_write = 0;
    bus.branch_cond = 0; bus.branch_target = 0; bus.jump_target = 0;
    bus.mem_ack = 0;
    m_pc = 0; m_ret = 0; m_cyc = 0;

    #12;
    check("rst_pc", bus.pc, 8'h00);
    check("rst_strobes", {bus.ir_load, bus.mem_req, bus.mem_we, bus.rf_we}, 4'b0000);
    check("rst_busy_halted", {bus.busy, bus.halted}, 2'b00);
`ifdef PERF_CNT_EN
    check("rst_retired", retired_cnt, 0);
    check("rst_cycles", cycle_cnt, 0);
`endif
    #10 reset = 1'b0;
    check("idle_busy", bus.busy, 1'b0);

    // add, then load with 3 wait cycles, then store
    do_start(8'h10);
    do_instr(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
    do_instr(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 3);
    do_instr(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0);
    // beq taken, not taken, jmp and branch together
    do_instr(1, 1, 0, 0, 0, 0, 0, 8'h40, 8'h77, 0);
    do_instr(1, 0, 0, 0, 0, 0, 0, 8'h99, 8'h77, 0);
    do_instr(1, 1, 1, 0, 0, 0, 0, 8'h33, 8'hC0, 0);
    // jump to 0xFF then wrap on sequential instruction
    do_instr(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 0);
    do_instr(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
    check("wrap_pc", bus.pc, 8'h00);

    // halt, stay halted, then restart at 0x00
    do_instr(0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 0);
`ifdef PERF_CNT_EN
    check("halt_retired", retired_cnt, m_ret);
    check("halt_cycles", cycle_cnt, m_cyc);
`endif
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'($urandom);
      tick();
      check("halt_hold", {bus.halted, bus.busy, bus.rf_we}, 3'b100);
      check("halt_hold_pc", bus.pc, m_pc);
    end
    do_start(8'h00);

    // randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic mw;
      kind = $urandom_range(0, 3);
      mw   = 1'($urandom);
      case (kind)
        0: do_instr(0, 0, 0, 0, 0, 0, 1'($urandom), 8'($urandom), 8'($urandom), 0);
        1: do_instr(0, 0, 0, 0, !mw, mw, !mw, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
        2: do_instr(1, 1'($urandom), 0, 0, 0, 0, 0, 8'($urandom), 8'($urandom), 0);
        default: do_instr(1'($urandom), 1'($urandom), 1, 0, 0, 0, 1'($urandom),
                          8'($urandom), 8'($urandom), 0);
      endcase
`ifdef PERF_CNT_EN
      check("rand_retired", retired_cnt, m_ret);
      check("rand_cycles", cycle_cnt, m_cyc);
`endif
    end
    do_instr(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0);

    // three adds from a fresh start for the counters
    do_start(8'h20);
    for (int n = 0; n < 3; n++)
      do_instr(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
`ifdef PERF_CNT_EN
    check("three_add_retired", retired_cnt, 3);
    check("three_add_cycles", cycle_cnt, 12);
`endif
    check("three_add_pc", bus.pc, 8'h23);

    // reset asserted while in MEM
    bus.branch = 0; bus.jmp_ctrl = 0; bus.done_ctrl = 0;
    bus.mem_read = 1; bus.mem_write = 1; bus.mem_ack = 0;
    tick(); tick(); tick();
    check("pre_rst_mem_req", {bus.mem_req, bus.mem_we}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_mem_req", {bus.mem_req, bus.mem_we}, 2'b00);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_pc", bus.pc, 8'h00);
    #10 reset = 1'b0;
    bus.mem_read = 0; bus.mem_write = 0;
    tick();
    check("post_rst_idle", {bus.busy, bus.halted, bus.ir_load}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
